if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Instruction queue between the fetch stage and the decode stage; directly downstream of fetch.
- Buffers up to DEPTH {pc, instruction} pairs produced by fetch.
- Presents them to decode with a valid/ready handshake.
- Discards all buffered entries on a taken-branch flush from execute.
- Drives a canonical NOP to decode whenever no valid entry exists.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- AW, $clog2(DEPTH), pointer width (derived, do not override)
- XLEN, 32, pc and instruction width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents a pc/instruction pair
- in_ready  out  1  queue accepts a pair this cycle
- in_pc  in  XLEN  pc of the fetched instruction
- in_instr  in  XLEN  fetched instruction, already big-endian ordered
- flush  in  1  taken branch from execute; discard contents
- out_valid  out  1  head entry valid for decode
- out_ready  in  1  decode consumes head this cycle
- out_pc  out  XLEN  pc of head entry
- out_instr  out  XLEN  instruction of head entry, or NOP when empty
- count  out  AW+1  current occupancy, 0..DEPTH

Behaviour:
- State: storage array of DEPTH x {pc, instr}, wr_ptr[AW-1:0], rd_ptr[AW-1:0], count[AW:0].
- Reset (reset=1 at a clock edge) sets:
  - wr_ptr=0, rd_ptr=0, count=0.
  - All storage entries = {0, NOP}.
  - Outputs after reset: out_valid=0, out_pc=0, out_instr=NOP (32'h0000_0013), in_ready=1, count=0.
- Reset overrides flush, push and pop in the same cycle.
- Combinational outputs:
  - in_ready = (count != DEPTH). No pass-through when full, so in_ready does not depend on out_ready.
  - out_valid = (count != 0).
  - out_pc = storage[rd_ptr].pc when out_valid, else 0.
  - out_instr = storage[rd_ptr].instr when out_valid, else NOP.
- Push = in_valid & in_ready:
  - Write storage[wr_ptr]; wr_ptr+1 mod DEPTH (natural wrap).
- Pop = out_valid & out_ready:
  - rd_ptr+1 mod DEPTH. The storage entry itself is not cleared.
- count update (no flush):
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- Latency: an entry pushed at edge N is visible on out_* immediately after edge N; there is no same-cycle bypass. Into an empty queue, the minimum delay from in_valid to out_valid is 1 cycle.
- Full, count=DEPTH:
  - in_ready=0; in_valid is ignored.
  - A pop in that cycle frees one slot, visible as in_ready=1 in the next cycle.
- Empty, count=0:
  - out_ready is ignored; no pointer moves.
  - A push in that cycle makes out_valid=1 in the next cycle.
- Flush (priority over push/pop):
  - At the edge: wr_ptr=rd_ptr=0, count=0.
  - The same-cycle push is dropped and the same-cycle pop is a no-op.
  - In the next cycle, out_valid=0 and out_instr=NOP.
  - Storage contents are left stale, which is harmless because count gates the outputs.
- flush held for multiple cycles: the queue stays empty and in_ready stays 1, but every push is dropped.
- Wrap-around: pointers wrap modulo DEPTH. Ordering is strict FIFO across the wrap.
- Invariants, checked by assertions in the bench:
  - count <= DEPTH
  - (wr_ptr - rd_ptr) mod DEPTH == count mod DEPTH
  - No push while count==DEPTH; no pop while count==0.

Decomposition:
- Shared pipeline package holds:
  - XLEN constant.
  - NOP_INSTR = 32'h0000_0013 (addi x0,x0,0).
  - A packed if_id_entry type {pc, instr}, reused by the decode stage.
- One natural sub-module: if_id_queue_mem, a DEPTH x 2*XLEN register array with synchronous write, asynchronous read and synchronous reset-to-{0,NOP}.
- Pointer and count control stay in if_id_queue.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 and flush=1 driven -> count=0, out_valid=0, out_instr=32'h0000_0013, in_ready=1 after release.
- Single push: push {pc=0x100, instr=0x00500093} with out_ready=0 -> next cycle out_valid=1, out_pc=0x100, out_instr=0x00500093, count=1. Then set out_ready=1 for 1 cycle -> count=0, out_instr=NOP.
- Fill: DEPTH=4, push pcs 0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0. Push of pc 0x10 is ignored. Pop four -> pcs emerge 0x0,0x4,0x8,0xC in order.
- Simultaneous events:
  - count=2, push and pop same cycle -> count stays 2, head advances.
  - count=4 with in_valid=1 and out_ready=1 -> only the pop occurs; count=3 and in_ready=1 next cycle.
- Flush: count=3, flush=1 together with a push of pc 0x40 and a pop -> next cycle count=0, out_valid=0. pc 0x40 never appears; the next pushed pc 0x80 is the next out_pc.
- Wrap: stream 10 pushes with continuous pops (out_ready=1) -> pcs out in order, pointers wrap twice, count never exceeds 1, no assertion fires.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode pipeline definitions: datapath width, canonical NOP and
// the {pc, instr} entry carried from fetch to decode.
package if_id_queue_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the fetch/decode queue: synchronous write, asynchronous
// read, synchronous reset of every entry to a fixed value.
module if_id_queue_mem #(
    parameter int             DEPTH   = 4,
    parameter int             W       = 64,
    parameter logic [W-1:0]   RST_VAL = '0,
    localparam int            AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RST_VAL;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO with a
// valid/ready handshake on both sides, flushed by a taken branch.
module if_id_queue #(
    parameter int  DEPTH = 4,
    parameter int  XLEN  = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [AW:0]     count
);

    import if_id_queue_pkg::*;

    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [XLEN-1:0] NOP      = XLEN'(NOP_INSTR);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic [2*XLEN-1:0] rd_entry;

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head is gated by occupancy so stale storage never reaches decode.
    assign out_pc    = out_valid ? rd_entry[2*XLEN-1:XLEN] : '0;
    assign out_instr = out_valid ? rd_entry[XLEN-1:0]      : NOP;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    if_id_queue_mem #(
        .DEPTH   (DEPTH),
        .W       (2*XLEN),
        .RST_VAL ({{XLEN{1'b0}}, NOP})
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized and directed stimulus for if_id_queue checked against a
// queue-based reference model of the fetch/decode FIFO.
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_pc = '0;
    logic [XLEN-1:0] in_instr = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [AW:0]     count;

    int checks = 0;
    int failures = 0;

    // Reference model: a plain queue of {pc, instr}; unknown until first reset.
    logic [63:0] model_q[$];
    bit          model_known = 1'b0;

    if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: apply inputs after negedge, compare outputs, advance model at posedge.
    task automatic step(input bit rst, input bit iv, input logic [31:0] pc,
                        input logic [31:0] ins, input bit fl, input bit ordy);
        int  sz;
        bit  do_push;
        bit  do_pop;
        int  ptr_diff;
        reset     = rst;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        flush     = fl;
        out_ready = ordy;
        #1;
        sz = model_q.size();
        if (model_known) begin
            check_eq("count", 64'(count), 64'(sz));
            check_eq("in_ready", 64'(in_ready), 64'(sz != DEPTH));
            check_eq("out_valid", 64'(out_valid), 64'(sz != 0));
            check_eq("out_pc", 64'(out_pc), (sz != 0) ? 64'(model_q[0][63:32]) : 64'h0);
            check_eq("out_instr", 64'(out_instr), (sz != 0) ? 64'(model_q[0][31:0]) : 64'(NOP));
            ptr_diff = (int'(dut.wr_ptr) - int'(dut.rd_ptr) + DEPTH) % DEPTH;
            check_eq("inv_ptr_count", 64'(ptr_diff), 64'(int'(count) % DEPTH));
            check_eq("inv_count_le_depth", 64'(int'(count) <= DEPTH), 64'(1));
        end
        do_pop  = (sz != 0) && ordy;
        do_push = iv && (sz != DEPTH);
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_known = 1'b1;
        end else if (fl) begin
            model_q.delete();
        end else if (model_known) begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({pc, ins});
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);

        // Reset held two cycles with push and flush also asserted.
        step(1, 1, 32'h200, 32'h1111, 1, 1);
        step(1, 1, 32'h204, 32'h2222, 1, 1);
        step(0, 0, 0, 0, 0, 0);

        // Single push, then one pop.
        step(0, 1, 32'h100, 32'h0050_0093, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // Fill, attempt overflow, drain in order.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 32'(i*4), 32'hA000 + 32'(i), 0, 0);
        step(0, 1, 32'h10, 32'hBEEF, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // count=2, push and pop together.
        step(0, 1, 32'h20, 32'h20, 0, 0);
        step(0, 1, 32'h24, 32'h24, 0, 0);
        step(0, 1, 32'h28, 32'h28, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // Full with push and pop requested: only the pop occurs.
        step(0, 1, 32'h2C, 32'h2C, 0, 0);
        step(0, 1, 32'h30, 32'h30, 0, 0);
        step(0, 1, 32'h34, 32'h34, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // Flush at count=3 alongside a push of 0x40 and a pop; then push 0x80.
        step(0, 1, 32'h40, 32'h40, 1, 1);
        step(0, 1, 32'h80, 32'h80, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Flush held for several cycles with pushes offered.
        for (int i = 0; i < 3; i++) step(0, 1, 32'h90 + 32'(i), 32'h90, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // Streaming across the pointer wrap.
        for (int i = 0; i < 10; i++) step(0, 1, 32'h1000 + 32'(i*4), 32'h13 + 32'(i << 7), 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 2) != 0),
                 $urandom, $urandom,
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
